// File: rtl/apcpu_pkg.sv
// Shared definitions for the APCPU decoder: operand formats, opcode
// classification and the default-width decoded record.
package apcpu_pkg;

  localparam int unsigned INSTR_W_DEF = 32;
  localparam int unsigned OPC_W_DEF   = 8;
  localparam int unsigned REG_W_DEF   = 3;
  localparam int unsigned DATA_W_DEF  = INSTR_W_DEF - OPC_W_DEF;

  localparam int unsigned OPC_PASS = 255;

  typedef enum logic [3:0] {
    F_PASS,
    F_AP,
    F_XYZ,
    F_XL6,
    F_XYX,
    F_X,
    F_Z,
    F_ZY,
    F_ILL
  } fmt_e;

  typedef struct packed {
    logic [OPC_W_DEF-1:0]  alu_code;
    logic [DATA_W_DEF-1:0] dec_data;
    logic [REG_W_DEF-1:0]  reg_x;
    logic [REG_W_DEF-1:0]  reg_y;
    logic [REG_W_DEF-1:0]  reg_z;
    logic                  illegal;
  } dec_rec_t;

  // Opcode value -> operand format; anything not listed is illegal.
  function automatic fmt_e opc_format(input int unsigned opc);
    fmt_e f;
    case (opc) inside
      OPC_PASS:                                               f = F_PASS;
      1, 2, 5, 6, 9, 11, 23, 24, [26:30], 33, 37, 40, 41:     f = F_AP;
      3, 4, 7, 8, 10, 12, 31, 32, 39, 42, 44, 45, 48:         f = F_XYZ;
      [13:16]:                                                f = F_XL6;
      [17:22], 38:                                            f = F_XYX;
      25, 34:                                                 f = F_X;
      35, 46:                                                 f = F_Z;
      36, 49:                                                 f = F_ZY;
      default:                                                f = F_ILL;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/apcpu_dec_format.sv
// Combinational decode of one instruction word into its output fields.
module apcpu_dec_format
  import apcpu_pkg::*;
#(
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned OPC_W   = 8,
  parameter int unsigned REG_W   = 3,
  parameter int unsigned DATA_W  = INSTR_W - OPC_W
) (
  input  logic [INSTR_W-1:0] instr,
  input  logic [REG_W-1:0]   ap_sel,
  output logic [OPC_W-1:0]   alu_code,
  output logic [DATA_W-1:0]  dec_data,
  output logic [REG_W-1:0]   reg_x,
  output logic [REG_W-1:0]   reg_y,
  output logic [REG_W-1:0]   reg_z,
  output logic               illegal
);

  logic [OPC_W-1:0] opc;
  logic [REG_W-1:0] rx, ry, rz;

  assign opc = instr[OPC_W-1:0];
  assign rx  = instr[OPC_W +: REG_W];
  assign ry  = instr[OPC_W+REG_W +: REG_W];
  assign rz  = instr[OPC_W+2*REG_W +: REG_W];

  // Route fields by format; unused fields stay zero.
  always_comb begin
    alu_code = opc;
    dec_data = '0;
    reg_x    = '0;
    reg_y    = '0;
    reg_z    = '0;
    illegal  = 1'b0;
    case (opc_format(32'(opc)))
      F_PASS: ;
      F_AP: begin
        dec_data = instr[INSTR_W-1:OPC_W];
        reg_x    = ap_sel;
        reg_z    = ap_sel;
      end
      F_XYZ: begin
        reg_x = rx;
        reg_y = ry;
        reg_z = rz;
      end
      F_XL6: begin
        reg_x    = rx;
        dec_data = DATA_W'(instr[OPC_W+REG_W +: 6]);
      end
      F_XYX: begin
        reg_x = rx;
        reg_y = ry;
        reg_z = rx;
      end
      F_X:  reg_x = rx;
      F_Z:  reg_z = rx;
      F_ZY: begin
        reg_z = rx;
        reg_y = ry;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/apcpu_decoder_pipe.sv
// Decoder front end with a 2-entry valid/ready output buffer and flush.
module apcpu_decoder_pipe
  import apcpu_pkg::*;
#(
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned OPC_W   = 8,
  parameter int unsigned REG_W   = 3,
  parameter int unsigned DATA_W  = INSTR_W - OPC_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] instr,
  input  logic [REG_W-1:0]   ap_sel,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OPC_W-1:0]   alu_code,
  output logic [DATA_W-1:0]  dec_data,
  output logic [REG_W-1:0]   reg_x,
  output logic [REG_W-1:0]   reg_y,
  output logic [REG_W-1:0]   reg_z,
  output logic               illegal
);

  typedef struct packed {
    logic [OPC_W-1:0]  alu_code;
    logic [DATA_W-1:0] dec_data;
    logic [REG_W-1:0]  reg_x;
    logic [REG_W-1:0]  reg_y;
    logic [REG_W-1:0]  reg_z;
    logic              illegal;
  } rec_t;

  rec_t       dec;
  rec_t       head;
  rec_t       mem [2];
  logic       rd_ptr;
  logic       wr_ptr;
  logic [1:0] count;
  logic       push;
  logic       pop;

  apcpu_dec_format #(
    .INSTR_W (INSTR_W),
    .OPC_W   (OPC_W),
    .REG_W   (REG_W),
    .DATA_W  (DATA_W)
  ) u_fmt (
    .instr    (instr),
    .ap_sel   (ap_sel),
    .alu_code (dec.alu_code),
    .dec_data (dec.dec_data),
    .reg_x    (dec.reg_x),
    .reg_y    (dec.reg_y),
    .reg_z    (dec.reg_z),
    .illegal  (dec.illegal)
  );

  // in_ready depends only on the registered count, never on out_ready.
  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  // Buffer storage, pointers and occupancy; flush overrides push and pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < 2; i++) mem[i] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= dec;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + 2'(push) - 2'(pop);
    end
  end

  // Head entry is presented only while valid; otherwise outputs read zero.
  always_comb begin
    head = '0;
    if (out_valid) head = mem[rd_ptr];
  end

  assign alu_code = head.alu_code;
  assign dec_data = head.dec_data;
  assign reg_x    = head.reg_x;
  assign reg_y    = head.reg_y;
  assign reg_z    = head.reg_z;
  assign illegal  = head.illegal;

endmodule
